// File: rtl/traffic_light_monitor.sv
// Passive checker for the two-approach light bus: decodes lamp pairs, tracks the
// six-phase rotation and flags encoding, conflict, sequence and dwell-time errors.
module traffic_light_monitor #(
    parameter int unsigned GREEN_CYC  = 6,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned ROT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       light_A,
    input  logic [2:0]       light_B,
    input  logic             clr_sticky,
    output logic             locked,
    output logic [2:0]       phase,
    output logic             err_encoding,
    output logic             err_conflict,
    output logic             err_sequence,
    output logic             err_timing,
    output logic [3:0]       err_sticky,
    output logic [ROT_W-1:0] rotations
);

    localparam logic [2:0] PH0  = 3'd0;
    localparam logic [2:0] PH5  = 3'd5;
    localparam logic [2:0] SYNC = 3'd7;

    localparam logic [2:0] P_GR   = 3'd0;
    localparam logic [2:0] P_YR   = 3'd1;
    localparam logic [2:0] P_RR   = 3'd2;
    localparam logic [2:0] P_RG   = 3'd3;
    localparam logic [2:0] P_RY   = 3'd4;
    localparam logic [2:0] P_CONF = 3'd5;
    localparam logic [2:0] P_BAD  = 3'd6;

    localparam logic [2:0] L_G = 3'b001;
    localparam logic [2:0] L_Y = 3'b010;
    localparam logic [2:0] L_R = 3'b100;

    localparam logic [CNT_W-1:0] DW_MAX = '1;

    function automatic logic [2:0] ph_pat(input logic [2:0] ph);
        case (ph)
            3'd0:    ph_pat = P_GR;
            3'd1:    ph_pat = P_YR;
            3'd2:    ph_pat = P_RR;
            3'd3:    ph_pat = P_RG;
            3'd4:    ph_pat = P_RY;
            3'd5:    ph_pat = P_RR;
            default: ph_pat = P_BAD;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] ph_len(input logic [2:0] ph);
        case (ph)
            3'd0, 3'd3: ph_len = CNT_W'(GREEN_CYC);
            3'd1, 3'd4: ph_len = CNT_W'(YELLOW_CYC);
            default:    ph_len = CNT_W'(ALLRED_CYC);
        endcase
    endfunction

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_dwell;
    logic             r_first;

    logic             w_a_oh, w_b_oh;
    logic [2:0]       w_pat;
    logic [2:0]       w_succ;
    logic [CNT_W-1:0] w_len;
    logic [2:0]       w_state_n;
    logic [CNT_W-1:0] w_dwell_n;
    logic             w_first_n;
    logic [ROT_W-1:0] w_rot_n;
    logic             w_enc, w_conf, w_seq, w_tim;

    // Classify the sampled lamp pair
    always_comb begin
        w_a_oh = (light_A == L_G) || (light_A == L_Y) || (light_A == L_R);
        w_b_oh = (light_B == L_G) || (light_B == L_Y) || (light_B == L_R);
        if (!w_a_oh || !w_b_oh)                       w_pat = P_BAD;
        else if (light_A == L_G && light_B == L_R)    w_pat = P_GR;
        else if (light_A == L_Y && light_B == L_R)    w_pat = P_YR;
        else if (light_A == L_R && light_B == L_R)    w_pat = P_RR;
        else if (light_A == L_R && light_B == L_G)    w_pat = P_RG;
        else if (light_A == L_R && light_B == L_Y)    w_pat = P_RY;
        else                                          w_pat = P_CONF;
    end

    // Next-state, dwell tracking and error pulses
    always_comb begin
        w_succ    = (r_state == PH5) ? PH0 : r_state + 3'd1;
        w_len     = ph_len(r_state);
        w_state_n = r_state;
        w_dwell_n = r_dwell;
        w_first_n = r_first;
        w_rot_n   = rotations;
        w_enc     = (w_pat == P_BAD);
        w_conf    = (w_pat == P_CONF);
        w_seq     = 1'b0;
        w_tim     = 1'b0;
        if (r_state == SYNC) begin
            if (w_pat == P_GR) begin
                w_state_n = PH0;
                w_dwell_n = CNT_W'(1);
                w_first_n = 1'b1;
            end
        end else if (w_pat == ph_pat(r_state)) begin
            if (r_dwell != DW_MAX) w_dwell_n = r_dwell + CNT_W'(1);
            w_tim = !r_first && (r_dwell == w_len);
        end else if (w_pat == ph_pat(w_succ)) begin
            w_state_n = w_succ;
            w_dwell_n = CNT_W'(1);
            w_first_n = 1'b0;
            w_tim     = !r_first && (r_dwell < w_len);
            if (r_state == PH5) w_rot_n = rotations + ROT_W'(1);
        end else begin
            w_state_n = SYNC;
            w_dwell_n = '0;
            w_seq     = (w_pat != P_BAD) && (w_pat != P_CONF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SYNC;
            r_dwell      <= '0;
            r_first      <= 1'b1;
            locked       <= 1'b0;
            err_encoding <= 1'b0;
            err_conflict <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            err_sticky   <= 4'b0;
            rotations    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_dwell      <= w_dwell_n;
            r_first      <= w_first_n;
            locked       <= (w_state_n != SYNC);
            err_encoding <= w_enc;
            err_conflict <= w_conf;
            err_sequence <= w_seq;
            err_timing   <= w_tim;
            err_sticky   <= (err_sticky & ~{4{clr_sticky}}) | {w_tim, w_seq, w_conf, w_enc};
            rotations    <= w_rot_n;
        end
    end

    assign phase = r_state;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

    logic        clk;
    logic        rst_n;
    logic [2:0]  light_A, light_B;
    logic        clr_sticky;
    logic        locked;
    logic [2:0]  phase;
    logic        err_encoding, err_conflict, err_sequence, err_timing;
    logic [3:0]  err_sticky;
    logic [15:0] rotations;

    int n_cmp = 0;
    int n_fail = 0;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic [2:0] pa  [6] = '{G, Y, R, R, R, R};
    logic [2:0] pb  [6] = '{R, R, R, G, Y, R};
    int         len [6] = '{6, 2, 2, 6, 2, 2};

    traffic_light_monitor #(
        .GREEN_CYC(6), .YELLOW_CYC(2), .ALLRED_CYC(2), .CNT_W(4), .ROT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .light_A(light_A), .light_B(light_B),
        .clr_sticky(clr_sticky), .locked(locked), .phase(phase),
        .err_encoding(err_encoding), .err_conflict(err_conflict),
        .err_sequence(err_sequence), .err_timing(err_timing),
        .err_sticky(err_sticky), .rotations(rotations)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] errs();
        return {err_timing, err_sequence, err_conflict, err_encoding};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one sample before the edge; return just after the edge with outputs updated
    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic clr);
        @(negedge clk);
        light_A    = a;
        light_B    = b;
        clr_sticky = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; light_A = G; light_B = R; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_phase", 32'(phase), 7);
        chk("rst_errs", 32'(errs()), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_rot", 32'(rotations), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three nominal rotations
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 6; p++)
                for (int k = 0; k < len[p]; k++) begin
                    cyc(pa[p], pb[p], 1'b0);
                    chk("nom_phase", 32'(phase), 32'(p));
                    chk("nom_errs", 32'(errs()), 0);
                    chk("nom_locked", 32'(locked), 1);
                end
        chk("nom_rot2", 32'(rotations), 2);
        cyc(G, R, 1'b0);
        chk("nom_rot3", 32'(rotations), 3);
        chk("nom_ph0", 32'(phase), 0);
        chk("nom_sticky", 32'(err_sticky), 0);

        // Short green: 5 GR then YR
        repeat (4) cyc(G, R, 1'b0);
        chk("sg_noerr", 32'(errs()), 0);
        cyc(Y, R, 1'b0);
        chk("sg_errs", 32'(errs()), 4'b1000);
        chk("sg_phase", 32'(phase), 1);
        chk("sg_locked", 32'(locked), 1);

        // Long yellow: 3 YR samples
        cyc(Y, R, 1'b0);
        chk("ly_2nd", 32'(errs()), 0);
        cyc(Y, R, 1'b0);
        chk("ly_3rd", 32'(errs()), 4'b1000);
        cyc(R, R, 1'b0);
        chk("ly_rr_errs", 32'(errs()), 0);
        chk("ly_rr_phase", 32'(phase), 2);
        cyc(R, R, 1'b0);
        for (int p = 3; p < 6; p++)
            for (int k = 0; k < len[p]; k++) cyc(pa[p], pb[p], 1'b0);
        chk("ly_tail_errs", 32'(errs()), 0);
        cyc(G, R, 1'b0);
        chk("rot4", 32'(rotations), 4);

        // Conflict while in PH0
        cyc(G, G, 1'b0);
        chk("cf_errs", 32'(errs()), 4'b0010);
        chk("cf_locked", 32'(locked), 0);
        chk("cf_phase", 32'(phase), 7);
        cyc(G, R, 1'b0);
        chk("cf_relock", 32'(phase), 0);
        chk("cf_relock_errs", 32'(errs()), 0);
        chk("cf_sticky", 32'(err_sticky), 4'b1010);
        cyc(G, R, 1'b1);
        chk("clr_sticky", 32'(err_sticky), 0);

        // Encoding error, then GR->RR skip
        cyc(3'b011, R, 1'b0);
        chk("enc_errs", 32'(errs()), 4'b0001);
        chk("enc_phase", 32'(phase), 7);
        cyc(G, R, 1'b0);
        chk("enc_relock", 32'(phase), 0);
        cyc(R, R, 1'b0);
        chk("seq_errs", 32'(errs()), 4'b0100);
        chk("seq_locked", 32'(locked), 0);
        chk("seq_sticky", 32'(err_sticky), 4'b0101);

        // GR out of turn in PH1 is not re-locked in the same cycle
        cyc(G, R, 1'b0);
        cyc(Y, R, 1'b0);
        chk("oot_ph1", 32'(phase), 1);
        cyc(G, R, 1'b0);
        chk("oot_errs", 32'(errs()), 4'b0100);
        chk("oot_phase", 32'(phase), 7);
        cyc(G, R, 1'b0);
        chk("oot_relock", 32'(phase), 0);

        // Timing error wins over a same-cycle clear
        cyc(Y, R, 1'b0);
        chk("tc_ph1_errs", 32'(errs()), 0);
        cyc(R, R, 1'b1);
        chk("tc_errs", 32'(errs()), 4'b1000);
        chk("tc_sticky", 32'(err_sticky), 4'b1000);

        // Dwell overrun flagged once, counter saturates, stays locked
        cyc(R, R, 1'b0);
        cyc(R, G, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            cyc(R, G, 1'b0);
            chk("sat_errs", 32'(errs()), (k == 7) ? 4'b1000 : 4'b0000);
            chk("sat_locked", 32'(locked), 1);
        end
        cyc(R, Y, 1'b0);
        chk("sat_exit_phase", 32'(phase), 4);
        chk("sat_exit_errs", 32'(errs()), 0);
        cyc(R, Y, 1'b0);
        cyc(R, R, 1'b0);
        cyc(R, R, 1'b0);
        cyc(G, R, 1'b0);
        chk("rot5", 32'(rotations), 5);

        // Asynchronous reset mid-PH3
        cyc(Y, R, 1'b0); cyc(Y, R, 1'b0);
        cyc(R, R, 1'b0); cyc(R, R, 1'b0);
        cyc(R, G, 1'b0); cyc(R, G, 1'b0);
        chk("pre_rst_phase", 32'(phase), 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_locked", 32'(locked), 0);
        chk("ar_phase", 32'(phase), 7);
        chk("ar_errs", 32'(errs()), 0);
        chk("ar_sticky", 32'(err_sticky), 0);
        chk("ar_rot", 32'(rotations), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(G, R, 1'b0);
        chk("post_rst_lock", 32'(phase), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
